imem_boot_loader: RTL and testbench
===================================

// Module: imem_boot_loader
// PURPOSE
//  Upstream feeder of the single-cycle core: receives a framed program image as a byte
//  stream (valid/ready) and writes it word by word into instruction memory.
//  Holds the core in reset until a complete image with a correct checksum is stored.
//  Sits between the serial byte receiver and the instruction memory write port / core reset.
// PARAMETERS
//  DEPTH        32     instruction memory depth in 32-bit words
//  ADDR_W       5      word index width, = $clog2(DEPTH)
//  TIMEOUT      1024   idle cycles mid-frame before the frame is abandoned
// PORTS
//  clk          in   1       clock
//  reset        in   1       synchronous, active-high
//  rx_valid     in   1       byte available from receiver
//  rx_data      in   8       received byte
//  rx_ready     out  1       loader accepts byte; transfer when rx_valid & rx_ready
//  imem_we      out  1       instruction memory write strobe, one cycle per word
//  imem_addr    out  ADDR_W  word index (not byte address)
//  imem_wdata   out  32      word to write
//  core_reset   out  1       active-high reset to processor core
//  load_done    out  1       image stored and verified
//  load_err     out  1       length or checksum failure (sticky until reset)
// BEHAVIOUR
//  Frame: 0xA5 magic, LEN_HI, LEN_LO (word count N), 4*N data bytes MSB-first, CSUM.
//  CSUM = XOR of LEN_HI, LEN_LO and all data bytes.
//  Reset values: rx_ready=1, imem_we=0, imem_addr=0, imem_wdata=0, core_reset=1,
//   load_done=0, load_err=0; state IDLE; byte, word, checksum and timeout counters = 0.
//  States / transitions (all on accepted byte unless stated):
//   IDLE:  0xA5 -> LEN_HI; any other byte discarded, stay.
//   LEN_HI -> LEN_LO; LEN_LO: N>DEPTH -> ERROR; N==0 -> CSUM; else -> DATA.
//   DATA:  shift byte into word register; on 4th byte imem_we=1 next cycle with
//          imem_addr=word index, imem_wdata=assembled word; after word N-1 -> CSUM.
//   CSUM:  match -> DONE; mismatch -> ERROR.
//   DONE:  core_reset=0, load_done=1, rx_ready=0; terminal until reset.
//   ERROR: core_reset=1, load_err=1, rx_ready=0; terminal until reset.
//  Latency: imem_we asserts exactly 1 cycle after the word's 4th byte handshake.
//  core_reset falls / load_done rises 1 cycle after the correct CSUM handshake.
//  rx_ready is 1 in IDLE..CSUM every cycle (no back-pressure while loading).
//  Timeout: in LEN_HI..CSUM, TIMEOUT consecutive cycles without a handshake -> IDLE,
//   counters cleared; already-written words stay in memory, core stays in reset.
//  A new 0xA5 inside DATA is treated as data (no resync except by timeout).
//  Words written before a bad checksum stay in memory; no rollback.
//  reset mid-frame: return to reset values next edge; partial image is ignored.
//  Counters wrap never: word index < DEPTH guaranteed by the LEN check.
// STRUCTURE
//  Package imem_boot_loader_pkg: state enum (IDLE,LEN_HI,LEN_LO,DATA,CSUM,DONE,ERROR),
//   BOOT_MAGIC=8'hA5, frame field widths.
//  One sub-module: boot_word_packer (byte shift register + 2-bit byte count,
//   word_valid pulse); FSM, checksum and timeout stay in the top.
// TESTING
//  Frame A5 00 02 | 20080005 | 2009000C | csum -> we @ addr0=0x20080005, addr1=0x2009000C,
//   core_reset falls 1 cycle after csum, load_done=1.
//  Bytes 00 FF A5 00 00 00 -> leading junk ignored, N=0, csum 00 ok -> done, no imem_we.
//  Same as test 1 with csum XOR 0x01 -> both words written, load_err=1, core_reset stays 1.
//  A5 00 21 (N=33 > DEPTH) -> ERROR after LEN_LO, no imem_we, rx_ready=0.
//  A5 00 01 AA then 1024 idle cycles -> back to IDLE; new full frame then loads correctly.
//  Reset pulse after 2 data bytes, then a full frame -> correct words, no stale bytes.
//  rx_valid gaps of random 0..10 cycles within a frame -> same result as test 1.

Source files
------------

// File: rtl/imem_boot_loader_pkg.sv
// Shared constants for the instruction-memory boot loader: frame magic, field widths
// and the FSM state encoding.
package imem_boot_loader_pkg;

  localparam logic [7:0] BOOT_MAGIC     = 8'hA5;
  localparam int         BYTE_W         = 8;
  localparam int         WORD_W         = 32;
  localparam int         LEN_W          = 16;
  localparam int         BYTES_PER_WORD = WORD_W / BYTE_W;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_LEN_HI = 3'd1;
  localparam state_t ST_LEN_LO = 3'd2;
  localparam state_t ST_DATA   = 3'd3;
  localparam state_t ST_CSUM   = 3'd4;
  localparam state_t ST_DONE   = 3'd5;
  localparam state_t ST_ERROR  = 3'd6;

  // States in which a partially received frame is live and the idle timer runs.
  function automatic logic in_frame(input state_t s);
    return (s == ST_LEN_HI) || (s == ST_LEN_LO) || (s == ST_DATA) || (s == ST_CSUM);
  endfunction

endpackage

// File: rtl/boot_word_packer.sv
// Assembles MSB-first bytes into 32-bit words; word_valid pulses for one cycle
// immediately after the edge that accepted a word's 4th byte.
module boot_word_packer
  import imem_boot_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              byte_valid,
  input  logic [BYTE_W-1:0] byte_data,
  output logic              last_byte,
  output logic              word_valid,
  output logic [WORD_W-1:0] word_data
);

  logic [1:0]                byte_cnt;
  logic [WORD_W-BYTE_W-1:0]  shift;

  assign last_byte = (byte_cnt == 2'd3);

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge value of its neighbours, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      byte_cnt   <= '0;
      shift      <= '0;
      word_valid <= 1'b0;
      word_data  <= '0;
    end else if (clear) begin
      // word_data is left alone: it only holds the last word already written.
      byte_cnt   <= '0;
      shift      <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= byte_valid && last_byte;
      if (byte_valid) begin
        byte_cnt <= byte_cnt + 2'd1;
        if (last_byte)
          word_data <= {shift, byte_data};
        else
          shift <= {shift[WORD_W-2*BYTE_W-1:0], byte_data};
      end
    end
  end

endmodule

// File: rtl/imem_boot_loader.sv
// Receives a framed program image over a byte stream, writes it into instruction
// memory and releases the core from reset once the checksum has been verified.
module imem_boot_loader
  import imem_boot_loader_pkg::*;
#(
  parameter int DEPTH   = 32,
  parameter int ADDR_W  = $clog2(DEPTH),
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_valid,
  input  logic [BYTE_W-1:0] rx_data,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [WORD_W-1:0] imem_wdata,
  output logic              core_reset,
  output logic              load_done,
  output logic              load_err
);

  localparam int CNT_W = ADDR_W + 1;
  localparam int TO_W  = $clog2(TIMEOUT + 1);

  state_t             state;
  logic [BYTE_W-1:0]  len_hi;
  logic [CNT_W-1:0]   word_total;
  logic [CNT_W-1:0]   word_cnt;
  logic [BYTE_W-1:0]  csum;
  logic [TO_W-1:0]    idle_cnt;

  logic               accept;
  logic               timeout;
  logic               last_byte;
  logic [LEN_W-1:0]   len_word;

  assign rx_ready   = (state != ST_DONE) && (state != ST_ERROR);
  assign core_reset = (state != ST_DONE);
  assign load_done  = (state == ST_DONE);
  assign load_err   = (state == ST_ERROR);

  assign accept   = rx_valid && rx_ready;
  assign len_word = {len_hi, rx_data};
  assign timeout  = in_frame(state) && !accept && (idle_cnt == TO_W'(TIMEOUT - 1));

  boot_word_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .clear      (timeout),
    .byte_valid (accept && (state == ST_DATA)),
    .byte_data  (rx_data),
    .last_byte  (last_byte),
    .word_valid (imem_we),
    .word_data  (imem_wdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      len_hi     <= '0;
      word_total <= '0;
      word_cnt   <= '0;
      csum       <= '0;
      idle_cnt   <= '0;
      imem_addr  <= '0;
    end else if (timeout) begin
      // Abandon the frame; words already written stay in memory.
      state    <= ST_IDLE;
      word_cnt <= '0;
      csum     <= '0;
      idle_cnt <= '0;
    end else begin
      idle_cnt <= (in_frame(state) && !accept) ? idle_cnt + TO_W'(1) : '0;
      if (accept) begin
        case (state)
          ST_IDLE: begin
            if (rx_data == BOOT_MAGIC) begin
              state    <= ST_LEN_HI;
              csum     <= '0;
              word_cnt <= '0;
            end
          end
          ST_LEN_HI: begin
            len_hi <= rx_data;
            csum   <= csum ^ rx_data;
            state  <= ST_LEN_LO;
          end
          ST_LEN_LO: begin
            csum       <= csum ^ rx_data;
            word_total <= len_word[CNT_W-1:0];
            if (len_word > LEN_W'(DEPTH))
              state <= ST_ERROR;
            else if (len_word == '0)
              state <= ST_CSUM;
            else
              state <= ST_DATA;
          end
          ST_DATA: begin
            csum <= csum ^ rx_data;
            if (last_byte) begin
              imem_addr <= word_cnt[ADDR_W-1:0];
              word_cnt  <= word_cnt + CNT_W'(1);
              if (word_cnt + CNT_W'(1) == word_total)
                state <= ST_CSUM;
            end
          end
          ST_CSUM: state <= (rx_data == csum) ? ST_DONE : ST_ERROR;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench for imem_boot_loader: directed frames plus randomized images,
// each compared against a frame-level reference parser.
module tb_imem_boot_loader;
  import imem_boot_loader_pkg::*;

  localparam int DEPTH   = 32;
  localparam int ADDR_W  = 5;
  localparam int TIMEOUT = 1024;

  logic              clk = 1'b0;
  logic              reset;
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              core_reset;
  logic              load_done;
  logic              load_err;

  int tests = 0;
  int fails = 0;

  logic [7:0]        frame_q[$];
  logic [31:0]       img[$];
  logic [ADDR_W-1:0] exp_addr[$];
  logic [31:0]       exp_data[$];
  logic [ADDR_W-1:0] got_addr[$];
  logic [31:0]       got_data[$];
  logic              exp_done;
  logic              exp_err;

  imem_boot_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_ready   (rx_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_reset (core_reset),
    .load_done  (load_done),
    .load_err   (load_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!reset && imem_we) begin
      got_addr.push_back(imem_addr);
      got_data.push_back(imem_wdata);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
    @(negedge clk);
    reset = 1'b0;
    got_addr.delete(); got_data.delete();
  endtask

  // Presents one byte and returns #1 after the edge that accepted it.
  task automatic send_byte(input logic [7:0] b);
    bit ok = 0;
    @(negedge clk);
    rx_valid = 1'b1; rx_data = b;
    for (int i = 0; i < 8; i++) begin
      if (rx_ready) begin
        @(posedge clk); #1; ok = 1; break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      tests++; fails++;
      $display("FAIL handshake: byte %02h not accepted, rx_ready=%0b required 1", b, rx_ready);
      rx_valid = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    if (n == 0) return;
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic send_stream(input int gap_max);
    foreach (frame_q[k]) begin
      send_byte(frame_q[k]);
      idle((gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0);
    end
    idle(1);
  endtask

  task automatic build_frame(input logic [7:0] corrupt);
    logic [15:0] n;
    logic [7:0]  x;
    n = 16'(img.size());
    frame_q.delete();
    frame_q.push_back(BOOT_MAGIC);
    frame_q.push_back(n[15:8]);
    frame_q.push_back(n[7:0]);
    x = n[15:8] ^ n[7:0];
    foreach (img[w]) begin
      for (int b = 3; b >= 0; b--) begin
        frame_q.push_back(img[w][8*b +: 8]);
        x ^= img[w][8*b +: 8];
      end
    end
    frame_q.push_back(x ^ corrupt);
  endtask

  // Reference parser: walks the byte list by frame rules and lists expected writes.
  task automatic run_model();
    int          i;
    logic [15:0] n;
    logic [7:0]  x;
    exp_addr.delete(); exp_data.delete();
    exp_done = 1'b0; exp_err = 1'b0;
    i = 0;
    while (i < frame_q.size() && frame_q[i] != BOOT_MAGIC) i++;
    i++;
    if (i + 2 > frame_q.size()) return;
    n = {frame_q[i], frame_q[i+1]};
    x = frame_q[i] ^ frame_q[i+1];
    i += 2;
    if (n > DEPTH) begin exp_err = 1'b1; return; end
    for (int w = 0; w < int'(n); w++) begin
      if (i + 4 > frame_q.size()) return;
      exp_addr.push_back(ADDR_W'(w));
      exp_data.push_back({frame_q[i], frame_q[i+1], frame_q[i+2], frame_q[i+3]});
      x ^= frame_q[i] ^ frame_q[i+1] ^ frame_q[i+2] ^ frame_q[i+3];
      i += 4;
    end
    if (i >= frame_q.size()) return;
    if (frame_q[i] == x) exp_done = 1'b1; else exp_err = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    tests++;
    if ({rx_ready, imem_we, imem_addr, imem_wdata, core_reset, load_done, load_err} !==
        {1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL reset_values: rdy=%0b we=%0b addr=%0d wdata=%08h crst=%0b done=%0b err=%0b required 1 0 0 00000000 1 0 0",
               rx_ready, imem_we, imem_addr, imem_wdata, core_reset, load_done, load_err);
    end
  endtask

  task automatic test_basic();
    do_reset();
    img = '{32'h20080005, 32'h2009000C};
    build_frame(8'h00);
    foreach (frame_q[k]) begin
      send_byte(frame_q[k]);
      if (k == 5 || k == 7) begin
        tests++;
        if (imem_we !== 1'b0) begin
          fails++; $display("FAIL basic_we_idle byte%0d: imem_we=%0b required 0", k, imem_we);
        end
      end
      if (k == 6 || k == 10) begin
        tests++;
        if ({imem_we, imem_addr, imem_wdata} !==
            {1'b1, (k == 6) ? 5'd0 : 5'd1, (k == 6) ? 32'h20080005 : 32'h2009000C}) begin
          fails++;
          $display("FAIL basic_write byte%0d: we=%0b addr=%0d data=%08h", k, imem_we, imem_addr, imem_wdata);
        end
        if (k == 10) begin
          tests++;
          if ({core_reset, load_done} !== 2'b10) begin
            fails++; $display("FAIL basic_pre_csum: core_reset=%0b load_done=%0b required 1 0", core_reset, load_done);
          end
        end
      end
    end
    tests++;
    if ({core_reset, load_done, load_err} !== 3'b010) begin
      fails++;
      $display("FAIL basic_post_csum: core_reset=%0b load_done=%0b load_err=%0b required 0 1 0", core_reset, load_done, load_err);
    end
    idle(1);
    tests++;
    if (rx_ready !== 1'b0) begin
      fails++; $display("FAIL basic_done_ready: rx_ready=%0b required 0", rx_ready);
    end
    tests++;
    if (got_addr.size() != 2) begin
      fails++; $display("FAIL basic_write_count: got %0d required 2", got_addr.size());
    end
  endtask

  task automatic test_junk_zero_len();
    do_reset();
    frame_q = '{8'h00, 8'hFF, 8'hA5, 8'h00, 8'h00, 8'h00};
    run_model();
    send_stream(0);
    tests++;
    if ({load_done, load_err, core_reset, 32'(got_addr.size())} !== {exp_done, exp_err, ~exp_done, 32'd0}) begin
      fails++;
      $display("FAIL zero_len: done=%0b err=%0b crst=%0b writes=%0d required %0b %0b %0b 0",
               load_done, load_err, core_reset, got_addr.size(), exp_done, exp_err, ~exp_done);
    end
  endtask

  task automatic test_bad_csum();
    do_reset();
    img = '{32'h20080005, 32'h2009000C};
    build_frame(8'h01);
    run_model();
    send_stream(0);
    tests++;
    if ({load_done, load_err, core_reset, rx_ready} !== {exp_done, exp_err, 1'b1, 1'b0}) begin
      fails++;
      $display("FAIL bad_csum: done=%0b err=%0b crst=%0b rdy=%0b required %0b %0b 1 0",
               load_done, load_err, core_reset, rx_ready, exp_done, exp_err);
    end
    tests++;
    if (got_addr.size() != exp_addr.size()) begin
      fails++; $display("FAIL bad_csum_writes: got %0d required %0d", got_addr.size(), exp_addr.size());
    end else foreach (exp_addr[k]) begin
      tests++;
      if ({got_addr[k], got_data[k]} !== {exp_addr[k], exp_data[k]}) begin
        fails++;
        $display("FAIL bad_csum_word%0d: got %0d:%08h required %0d:%08h", k, got_addr[k], got_data[k], exp_addr[k], exp_data[k]);
      end
    end
  endtask

  task automatic test_len_error();
    do_reset();
    frame_q = '{8'hA5, 8'h00, 8'h21};
    run_model();
    send_stream(0);
    tests++;
    if ({load_err, load_done, core_reset, rx_ready, 32'(got_addr.size())} !==
        {exp_err, 1'b0, 1'b1, 1'b0, 32'd0}) begin
      fails++;
      $display("FAIL len_error: err=%0b done=%0b crst=%0b rdy=%0b writes=%0d required %0b 0 1 0 0",
               load_err, load_done, core_reset, rx_ready, got_addr.size(), exp_err);
    end
  endtask

  task automatic test_len_max();
    do_reset();
    img.delete();
    for (int w = 0; w < DEPTH; w++) img.push_back($urandom);
    build_frame(8'h00);
    run_model();
    send_stream(0);
    tests++;
    if ({load_done, load_err, core_reset} !== {exp_done, exp_err, ~exp_done}) begin
      fails++; $display("FAIL len_max_status: done=%0b err=%0b crst=%0b required %0b %0b %0b",
                        load_done, load_err, core_reset, exp_done, exp_err, ~exp_done);
    end
    tests++;
    if (got_addr.size() != exp_addr.size()) begin
      fails++; $display("FAIL len_max_writes: got %0d required %0d", got_addr.size(), exp_addr.size());
    end else foreach (exp_addr[k]) begin
      tests++;
      if ({got_addr[k], got_data[k]} !== {exp_addr[k], exp_data[k]}) begin
        fails++;
        $display("FAIL len_max_word%0d: got %0d:%08h required %0d:%08h", k, got_addr[k], got_data[k], exp_addr[k], exp_data[k]);
      end
    end
  endtask

  // gap TIMEOUT-1 keeps the frame alive; gap TIMEOUT abandons it.
  task automatic test_timeout(input bit expire);
    do_reset();
    img = '{32'hAABBCCDD};
    build_frame(8'h00);
    for (int k = 0; k < 4; k++) send_byte(frame_q[k]);
    idle(expire ? TIMEOUT : TIMEOUT - 1);
    if (expire) begin
      img = '{32'h20080005, 32'h2009000C};
      build_frame(8'h00);
      send_stream(0);
    end else begin
      for (int k = 4; k < frame_q.size(); k++) send_byte(frame_q[k]);
      idle(1);
    end
    run_model();
    tests++;
    if ({load_done, load_err, core_reset} !== {exp_done, exp_err, ~exp_done}) begin
      fails++; $display("FAIL timeout%0b_status: done=%0b err=%0b crst=%0b required %0b %0b %0b",
                        expire, load_done, load_err, core_reset, exp_done, exp_err, ~exp_done);
    end
    tests++;
    if (got_addr.size() != exp_addr.size()) begin
      fails++; $display("FAIL timeout%0b_writes: got %0d required %0d", expire, got_addr.size(), exp_addr.size());
    end else foreach (exp_addr[k]) begin
      tests++;
      if ({got_addr[k], got_data[k]} !== {exp_addr[k], exp_data[k]}) begin
        fails++;
        $display("FAIL timeout%0b_word%0d: got %0d:%08h required %0d:%08h", expire, k, got_addr[k], got_data[k], exp_addr[k], exp_data[k]);
      end
    end
  endtask

  task automatic test_reset_midframe();
    do_reset();
    img = '{32'h20080005, 32'h2009000C};
    build_frame(8'h00);
    for (int k = 0; k < 5; k++) send_byte(frame_q[k]);
    do_reset();
    tests++;
    if ({rx_ready, imem_we, core_reset, load_done, load_err} !== 5'b10100) begin
      fails++; $display("FAIL midreset_values: rdy=%0b we=%0b crst=%0b done=%0b err=%0b required 1 0 1 0 0",
                        rx_ready, imem_we, core_reset, load_done, load_err);
    end
    img = '{32'h13572468, 32'h9ABCDEF0};
    build_frame(8'h00);
    run_model();
    send_stream(0);
    tests++;
    if ({load_done, load_err, core_reset} !== {exp_done, exp_err, ~exp_done}) begin
      fails++; $display("FAIL midreset_status: done=%0b err=%0b crst=%0b required %0b %0b %0b",
                        load_done, load_err, core_reset, exp_done, exp_err, ~exp_done);
    end
    tests++;
    if (got_addr.size() != exp_addr.size()) begin
      fails++; $display("FAIL midreset_writes: got %0d required %0d", got_addr.size(), exp_addr.size());
    end else foreach (exp_addr[k]) begin
      tests++;
      if ({got_addr[k], got_data[k]} !== {exp_addr[k], exp_data[k]}) begin
        fails++;
        $display("FAIL midreset_word%0d: got %0d:%08h required %0d:%08h", k, got_addr[k], got_data[k], exp_addr[k], exp_data[k]);
      end
    end
  endtask

  task automatic test_random_gaps();
    for (int r = 0; r < 6; r++) begin
      do_reset();
      img.delete();
      if (r == 0) img = '{32'h20080005, 32'h2009000C};
      else repeat ($urandom_range(6, 1)) img.push_back($urandom);
      build_frame((r % 3 == 2) ? 8'($urandom_range(255, 1)) : 8'h00);
      run_model();
      send_stream(10);
      tests++;
      if ({load_done, load_err, core_reset} !== {exp_done, exp_err, ~exp_done}) begin
        fails++; $display("FAIL gaps%0d_status: done=%0b err=%0b crst=%0b required %0b %0b %0b",
                          r, load_done, load_err, core_reset, exp_done, exp_err, ~exp_done);
      end
      tests++;
      if (got_addr.size() != exp_addr.size()) begin
        fails++; $display("FAIL gaps%0d_writes: got %0d required %0d", r, got_addr.size(), exp_addr.size());
      end else foreach (exp_addr[k]) begin
        tests++;
        if ({got_addr[k], got_data[k]} !== {exp_addr[k], exp_data[k]}) begin
          fails++;
          $display("FAIL gaps%0d_word%0d: got %0d:%08h required %0d:%08h", r, k, got_addr[k], got_data[k], exp_addr[k], exp_data[k]);
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (3) @(negedge clk);
    test_reset();
    test_basic();
    test_junk_zero_len();
    test_bad_csum();
    test_len_error();
    test_len_max();
    test_timeout(1'b0);
    test_timeout(1'b1);
    test_reset_midframe();
    test_random_gaps();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
